// File: rtl/execute_banner_renderer_pkg.sv
// Shared types and constants for the EXECUTE banner renderer.
// The ROM row stride and bitmap size live here so the ROM and the renderer agree.
package banner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLINK = 2'd1,
        HOLD  = 2'd2
    } banner_state_t;

    localparam int SPR_W  = 60;
    localparam int SPR_H  = 20;
    localparam int ADDR_W = 11;

    // Row base address; the 60-wide bitmap uses 64r - 4r so no multiplier is built.
    function automatic logic [ADDR_W-1:0] row_offset(input logic [ADDR_W-1:0] row,
                                                     input int stride);
        logic [ADDR_W-1:0] stride_v;
        stride_v = ADDR_W'(stride);
        if (stride == 60)
            return (row << 6) - (row << 2);
        else
            return row * stride_v;
    endfunction

endpackage

// File: rtl/execute_banner_renderer_if.sv
// Bitmap ROM read bus: the renderer drives the address, the ROM answers combinationally.
interface execute_banner_renderer_if;

    logic [10:0] rom_addr;
    logic        rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/banner_seq_fsm.sv
// Frame-synchronous visibility sequencer: hidden -> blinking -> held on -> hidden.
// vis_frame only changes on a VS rising edge so the banner never tears mid-frame.
module banner_seq_fsm
    import banner_pkg::*;
#(
    parameter int BLINK_FRAMES  = 15,
    parameter int BLINK_TOGGLES = 6,
    parameter int HOLD_FRAMES   = 120
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    input  logic start,
    output logic busy,
    output logic vis_frame
);

    localparam int FMAX  = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
    localparam int CNT_W = $clog2(FMAX + 1);
    localparam int TOG_W = $clog2(BLINK_TOGGLES + 1);

    banner_state_t    state, state_nxt;
    logic [CNT_W-1:0] frame_cnt, frame_nxt;
    logic [TOG_W-1:0] toggle_cnt, toggle_nxt;
    logic             vis, vis_nxt;
    logic             vs_q;
    logic             tick;

    // vs_q resets high so coming out of reset with VS high is not seen as an edge.
    assign tick = vs & ~vs_q;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q       <= 1'b1;
            state      <= IDLE;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            vis        <= 1'b0;
            vis_frame  <= 1'b0;
        end else begin
            vs_q       <= vs;
            state      <= state_nxt;
            frame_cnt  <= frame_nxt;
            toggle_cnt <= toggle_nxt;
            vis        <= vis_nxt;
            if (tick)
                vis_frame <= vis_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_nxt  = frame_cnt;
        toggle_nxt = toggle_cnt;
        vis_nxt    = vis;
        case (state)
            IDLE: begin
                vis_nxt = 1'b0;
                if (start) begin
                    state_nxt  = BLINK;
                    frame_nxt  = '0;
                    toggle_nxt = '0;
                    vis_nxt    = 1'b1;
                end
            end
            BLINK: begin
                if (tick) begin
                    if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                        frame_nxt  = '0;
                        toggle_nxt = toggle_cnt + 1'b1;
                        vis_nxt    = ~vis;
                        if (toggle_cnt == TOG_W'(BLINK_TOGGLES - 1)) begin
                            state_nxt = HOLD;
                            vis_nxt   = 1'b1;
                        end
                    end else begin
                        frame_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (frame_cnt == CNT_W'(HOLD_FRAMES - 1)) begin
                        state_nxt = IDLE;
                        frame_nxt = '0;
                        vis_nxt   = 1'b0;
                    end else begin
                        frame_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                vis_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/execute_banner_renderer.sv
// Maps DrawX/DrawY into the scaled EXECUTE bitmap and emits a registered pixel/colour
// two clocks later; visibility comes from the frame-synchronous sequencer.
module execute_banner_renderer
    import banner_pkg::*;
#(
    parameter int          SPR_W         = banner_pkg::SPR_W,
    parameter int          SPR_H         = banner_pkg::SPR_H,
    parameter int          SCALE_LOG2    = 1,
    parameter int          BLINK_FRAMES  = 15,
    parameter int          BLINK_TOGGLES = 6,
    parameter int          HOLD_FRAMES   = 120,
    parameter logic [23:0] FG_COLOR      = 24'hFFFFFF
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic                      VS,
    input  logic [9:0]                OriginX,
    input  logic [9:0]                OriginY,
    input  logic                      start,
    execute_banner_renderer_if.master rom,
    output logic                      pixel_on,
    output logic [7:0]                Red,
    output logic [7:0]                Green,
    output logic [7:0]                Blue,
    output logic                      busy
);

    localparam logic [ADDR_W-1:0] BOX_W = ADDR_W'(SPR_W << SCALE_LOG2);
    localparam logic [ADDR_W-1:0] BOX_H = ADDR_W'(SPR_H << SCALE_LOG2);

    logic signed [ADDR_W-1:0] dx_p0, dy_p0;
    logic        [ADDR_W-1:0] dxu_p0, dyu_p0;
    logic        [ADDR_W-1:0] col_p0, row_p0, addr_p0;
    logic                     inbox_p0, inbox_p1;
    logic                     pix_p1;
    logic                     vis_frame;

    banner_seq_fsm #(
        .BLINK_FRAMES  (BLINK_FRAMES),
        .BLINK_TOGGLES (BLINK_TOGGLES),
        .HOLD_FRAMES   (HOLD_FRAMES)
    ) u_seq (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .vs        (VS),
        .start     (start),
        .busy      (busy),
        .vis_frame (vis_frame)
    );

    // Stage 0: offsets, box test and bitmap address; a set bit 10 means left of / above origin.
    assign dx_p0    = $signed({1'b0, DrawX}) - $signed({1'b0, OriginX});
    assign dy_p0    = $signed({1'b0, DrawY}) - $signed({1'b0, OriginY});
    assign dxu_p0   = $unsigned(dx_p0);
    assign dyu_p0   = $unsigned(dy_p0);
    assign inbox_p0 = !dx_p0[ADDR_W-1] && !dy_p0[ADDR_W-1] &&
                      (dxu_p0 < BOX_W) && (dyu_p0 < BOX_H);
    assign col_p0   = dxu_p0 >> SCALE_LOG2;
    assign row_p0   = dyu_p0 >> SCALE_LOG2;
    assign addr_p0  = row_offset(row_p0, SPR_W) + col_p0;

    // Stage 1: ROM address and box flag registered.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom.rom_addr <= '0;
            inbox_p1     <= 1'b0;
        end else begin
            rom.rom_addr <= inbox_p0 ? addr_p0 : '0;
            inbox_p1     <= inbox_p0;
        end
    end

    assign pix_p1 = inbox_p1 & rom.rom_data & vis_frame;

    // Stage 2: foreground flag and colour registered together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_on            <= 1'b0;
            {Red, Green, Blue}  <= 24'h0;
        end else begin
            pixel_on            <= pix_p1;
            {Red, Green, Blue}  <= pix_p1 ? FG_COLOR : 24'h0;
        end
    end

endmodule
